// File: rtl/etc_planar_block_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : etc_planar_block_sequencer_pkg
// Brief   : Shared constants, state encoding and RGBA packing for the ETC2
//           planar block sequencer.
// Revision: 1.0 - initial release
// ============================================================================
package etc_planar_block_sequencer_pkg;

    localparam int ETC_PIX_PER_BLK = 16;
    localparam int ETC_IDX_W       = 4;
    localparam int ETC_RGBA_W      = 32;

    typedef enum logic [1:0] {
        SEQ_IDLE  = 2'd0,
        SEQ_RUN   = 2'd1,
        SEQ_DRAIN = 2'd2
    } seq_state_e;

    // Output pixel word is {a,b,g,r}, red in the least significant byte.
    function automatic logic [ETC_RGBA_W-1:0] etc_pack_rgba(
        input logic [7:0] r,
        input logic [7:0] g,
        input logic [7:0] b,
        input logic [7:0] a
    );
        return {a, b, g, r};
    endfunction

endpackage
`default_nettype wire

// File: rtl/etc_planar_block_sequencer_fifo.sv
`default_nettype none
// ============================================================================
// Module  : etc_pix_skid_fifo
// Brief   : Small circular output buffer holding generator results until the
//           tile writer accepts them.
// Revision: 1.0 - initial release
// ============================================================================
module etc_pix_skid_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                       sclk,
    input  logic                       rsrt,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_PTR_W-1:0] c_PTR_LAST = c_PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic               w_full;
    logic               w_do_push;
    logic               w_do_pop;

    assign w_full    = (r_count == c_CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign w_do_push = push & ~w_full;
    assign w_do_pop  = pop & ~empty;
    assign head      = r_mem[r_rd_ptr];
    assign count     = r_count;

    // Storage, pointers and occupancy; reset flushes everything to zero
    always_ff @(posedge sclk or negedge rsrt) begin
        if (!rsrt) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= push_data;
                r_wr_ptr        <= (r_wr_ptr == c_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == c_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // The sequencer's credit scheme guarantees room for every push
    err_push_full: assert property (@(posedge sclk) disable iff (!rsrt) !(push && w_full));

endmodule
`default_nettype wire

// File: rtl/etc_planar_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : etc_planar_block_sequencer
// Brief   : Walks the ETC2 planar colour generator over the 16 pixels of one
//           4x4 block and streams the RGBA results downstream.
// Revision: 1.0 - initial release
// ============================================================================
module etc_planar_block_sequencer
    import etc_planar_block_sequencer_pkg::*;
#(
    parameter int PIX_PER_BLK = ETC_PIX_PER_BLK,
    parameter int FIFO_DEPTH  = 2,
    parameter int TAG_W       = 8
) (
    input  logic                  sclk,
    input  logic                  rsrt,
    input  logic                  blk_valid,
    output logic                  blk_ready,
    input  logic                  blk_alpha,
    input  logic [TAG_W-1:0]      blk_tag,
    input  logic [23:0]           blk_c0,
    input  logic [23:0]           blk_c1,
    input  logic [23:0]           blk_c2,
    output logic                  gen_rtr,
    output logic [ETC_IDX_W-1:0]  gen_pixIdx,
    output logic                  gen_alpha,
    output logic [23:0]           gen_c0,
    output logic [23:0]           gen_c1,
    output logic [23:0]           gen_c2,
    input  logic                  gen_rts,
    input  logic [7:0]            gen_r,
    input  logic [7:0]            gen_g,
    input  logic [7:0]            gen_b,
    input  logic [7:0]            gen_a,
    output logic                  pix_valid,
    input  logic                  pix_ready,
    output logic [ETC_RGBA_W-1:0] pix_rgba,
    output logic [ETC_IDX_W-1:0]  pix_xy,
    output logic [TAG_W-1:0]      pix_tag,
    output logic                  pix_last,
    output logic                  busy
);

    localparam int c_CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int c_SUM_W  = c_CNT_W + 1;
    localparam int c_FIFO_W = TAG_W + 1 + ETC_IDX_W + ETC_RGBA_W;
    localparam logic [ETC_IDX_W-1:0] c_LAST_IDX = ETC_IDX_W'(PIX_PER_BLK - 1);

    seq_state_e           r_state;
    seq_state_e           w_state_nxt;
    logic [ETC_IDX_W-1:0] r_idx;
    logic [ETC_IDX_W-1:0] r_idx_d;
    logic                 r_rtr_d;
    logic [TAG_W-1:0]     r_tag;
    logic                 w_accept;
    logic                 w_pop;
    logic                 w_has_credit;
    logic [c_SUM_W-1:0]   w_used;
    logic [c_SUM_W-1:0]   w_limit;
    logic [c_CNT_W-1:0]   w_fifo_count;
    logic                 w_fifo_empty;
    logic [c_FIFO_W-1:0]  w_push_data;
    logic [c_FIFO_W-1:0]  w_head;

    assign w_pop = pix_valid & pix_ready;

    // A slot freed by this cycle's pop is reusable immediately; without it the
    // loop would bubble every other cycle with only two entries of buffering.
    assign w_used       = c_SUM_W'(w_fifo_count) + c_SUM_W'(r_rtr_d);
    assign w_limit      = c_SUM_W'(FIFO_DEPTH) + c_SUM_W'(w_pop);
    assign w_has_credit = (w_used < w_limit);

    // State register
    always_ff @(posedge sclk or negedge rsrt) begin
        if (!rsrt) begin
            r_state <= SEQ_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state, descriptor handshake and generator request
    always_comb begin
        w_state_nxt = r_state;
        blk_ready   = 1'b0;
        gen_rtr     = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            SEQ_IDLE: begin
                blk_ready = 1'b1;
                if (blk_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = SEQ_RUN;
                end
            end
            SEQ_RUN: begin
                gen_rtr = w_has_credit;
                if (w_has_credit && (r_idx == c_LAST_IDX)) begin
                    w_state_nxt = SEQ_DRAIN;
                end
            end
            SEQ_DRAIN: begin
                if (w_pop && pix_last) begin
                    w_state_nxt = SEQ_IDLE;
                end
            end
            default: w_state_nxt = SEQ_IDLE;
        endcase
    end

    assign busy = (r_state != SEQ_IDLE);

    // Descriptor latch, only loaded on the IDLE handshake
    always_ff @(posedge sclk or negedge rsrt) begin
        if (!rsrt) begin
            gen_alpha <= 1'b0;
            gen_c0    <= '0;
            gen_c1    <= '0;
            gen_c2    <= '0;
            r_tag     <= '0;
        end else if (w_accept) begin
            gen_alpha <= blk_alpha;
            gen_c0    <= blk_c0;
            gen_c1    <= blk_c1;
            gen_c2    <= blk_c2;
            r_tag     <= blk_tag;
        end
    end

    // Pixel index counter, advanced once per issued request
    always_ff @(posedge sclk or negedge rsrt) begin
        if (!rsrt) begin
            r_idx <= '0;
        end else if (w_accept) begin
            r_idx <= '0;
        end else if (gen_rtr) begin
            r_idx <= r_idx + 1'b1;
        end
    end

    assign gen_pixIdx = r_idx;

    // In-flight tracking: the generator answers exactly one cycle after rtr
    always_ff @(posedge sclk or negedge rsrt) begin
        if (!rsrt) begin
            r_rtr_d <= 1'b0;
            r_idx_d <= '0;
        end else begin
            r_rtr_d <= gen_rtr;
            if (gen_rtr) begin
                r_idx_d <= r_idx;
            end
        end
    end

    err_rts: assert property (@(posedge sclk) disable iff (!rsrt) (r_rtr_d == gen_rts));

    assign w_push_data = {r_tag, (r_idx_d == c_LAST_IDX), r_idx_d,
                          etc_pack_rgba(gen_r, gen_g, gen_b, gen_a)};

    etc_pix_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_FIFO_W)
    ) u_fifo (
        .sclk      (sclk),
        .rsrt      (rsrt),
        .push      (r_rtr_d),
        .push_data (w_push_data),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_fifo_count),
        .empty     (w_fifo_empty)
    );

    assign pix_valid = ~w_fifo_empty;
    assign {pix_tag, pix_last, pix_xy, pix_rgba} = w_head;

endmodule
`default_nettype wire

// File: tb/tb_etc_planar_block_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_etc_planar_block_sequencer
// Brief   : Self-checking bench with a planar-mode generator model and a
//           queue-based expected pixel stream.
// Revision: 1.0 - initial release
// ============================================================================
module tb_etc_planar_block_sequencer;

    localparam int TAG_W      = 8;
    localparam int FIFO_DEPTH = 2;
    localparam int PIX_W      = TAG_W + 1 + 4 + 32;
    typedef logic [PIX_W-1:0] pix_t;

    logic             sclk = 1'b0;
    logic             rsrt;
    logic             blk_valid, blk_ready, blk_alpha;
    logic [TAG_W-1:0] blk_tag;
    logic [23:0]      blk_c0, blk_c1, blk_c2;
    logic             gen_rtr, gen_alpha, gen_rts;
    logic [3:0]       gen_pixIdx;
    logic [23:0]      gen_c0, gen_c1, gen_c2;
    logic [7:0]       gen_r, gen_g, gen_b, gen_a;
    logic             pix_valid, pix_ready, pix_last, busy;
    logic [31:0]      pix_rgba;
    logic [3:0]       pix_xy;
    logic [TAG_W-1:0] pix_tag;

    always #5 sclk = ~sclk;

    etc_planar_block_sequencer #(.PIX_PER_BLK(16), .FIFO_DEPTH(FIFO_DEPTH), .TAG_W(TAG_W)) dut (
        .sclk(sclk), .rsrt(rsrt),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_alpha(blk_alpha), .blk_tag(blk_tag),
        .blk_c0(blk_c0), .blk_c1(blk_c1), .blk_c2(blk_c2),
        .gen_rtr(gen_rtr), .gen_pixIdx(gen_pixIdx), .gen_alpha(gen_alpha),
        .gen_c0(gen_c0), .gen_c1(gen_c1), .gen_c2(gen_c2),
        .gen_rts(gen_rts), .gen_r(gen_r), .gen_g(gen_g), .gen_b(gen_b), .gen_a(gen_a),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_rgba(pix_rgba),
        .pix_xy(pix_xy), .pix_tag(pix_tag), .pix_last(pix_last), .busy(busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // ETC2 planar colour: (x*(H-O) + y*(V-O) + 4*O + 2) >> 2, clamped to 0..255
    function automatic logic [7:0] planar_ch(input logic [7:0] o, input logic [7:0] h,
                                             input logic [7:0] v, input int x, input int y);
        int t;
        t = (x * (int'(h) - int'(o)) + y * (int'(v) - int'(o)) + 4 * int'(o) + 2) >>> 2;
        if (t < 0)   t = 0;
        if (t > 255) t = 255;
        return 8'(t);
    endfunction

    // Colours are {b,g,r}; x = idx[3:2], y = idx[1:0]; result word is {a,b,g,r}
    function automatic logic [31:0] planar_rgba(input logic [23:0] c0, input logic [23:0] c1,
                                                input logic [23:0] c2, input logic alpha,
                                                input logic [3:0] idx);
        int x, y;
        logic [7:0] r, g, b, a;
        x = int'(idx[3:2]);
        y = int'(idx[1:0]);
        r = planar_ch(c0[7:0],   c1[7:0],   c2[7:0],   x, y);
        g = planar_ch(c0[15:8],  c1[15:8],  c2[15:8],  x, y);
        b = planar_ch(c0[23:16], c1[23:16], c2[23:16], x, y);
        a = alpha ? 8'hFF : 8'h00;
        return {a, b, g, r};
    endfunction

    // Generator model: one-cycle latency, garbage whenever not requested
    always @(posedge sclk or negedge rsrt) begin
        if (!rsrt) begin
            gen_rts <= 1'b0;
            {gen_a, gen_b, gen_g, gen_r} <= '0;
        end else begin
            gen_rts <= gen_rtr;
            if (gen_rtr)
                {gen_a, gen_b, gen_g, gen_r} <= planar_rgba(gen_c0, gen_c1, gen_c2, gen_alpha, gen_pixIdx);
            else
                {gen_a, gen_b, gen_g, gen_r} <= $urandom;
        end
    end

    int cyc = 0;
    always @(posedge sclk) cyc++;

    // Downstream ready driver: 0 always, 1 pattern 1,0,0,1, 2 random, 3 manual
    int   rdy_mode = 0;
    int   rdy_ph = 0;
    logic manual_rdy = 1'b1;
    always @(posedge sclk) begin
        #1;
        case (rdy_mode)
            0: pix_ready = 1'b1;
            1: begin pix_ready = ((rdy_ph % 4) == 0) || ((rdy_ph % 4) == 3); rdy_ph++; end
            2: pix_ready = ($urandom_range(0, 9) < 7);
            default: pix_ready = manual_rdy;
        endcase
    end

    // Monitor and reference model
    pix_t        exp_q[$];
    int          outstanding = 0;
    int          blk_pix_cnt = 0;
    int          hs_cyc = 0, first_cyc = 0, last_cyc = 0;
    bit          stall_prev = 1'b0;
    pix_t        stall_data;
    logic [31:0] seen_rgba [16];

    always @(negedge sclk) begin : b_mon
        pix_t       obs, expv;
        logic       pop;
        logic [3:0] ix;
        obs = {pix_tag, pix_last, pix_xy, pix_rgba};
        pop = pix_valid && pix_ready;
        if (!rsrt) begin
            exp_q.delete();
            outstanding = 0;
            blk_pix_cnt = 0;
            stall_prev  = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", pix_valid, 1);
                chk("stall_data", obs, stall_data);
            end
            if (gen_rtr)
                chk("credit", (outstanding - int'(pop)) < FIFO_DEPTH, 1);
            if (blk_valid && blk_ready) begin
                hs_cyc = cyc;
                for (int i = 0; i < 16; i++) begin
                    ix = 4'(i);
                    exp_q.push_back({blk_tag, (i == 15), ix, planar_rgba(blk_c0, blk_c1, blk_c2, blk_alpha, ix)});
                end
            end
            if (pop) begin
                chk("pix_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    expv = exp_q.pop_front();
                    chk("pix", obs, expv);
                end
                seen_rgba[pix_xy] = pix_rgba;
                if (blk_pix_cnt == 0) first_cyc = cyc;
                blk_pix_cnt++;
                if (pix_last) begin
                    last_cyc    = cyc;
                    blk_pix_cnt = 0;
                end
            end
            outstanding = outstanding + int'(gen_rtr) - int'(pop);
            stall_prev  = pix_valid && !pix_ready;
            stall_data  = obs;
        end
    end

    task automatic wait_neg();
        @(negedge sclk);
        #1;
    endtask

    task automatic send_block(input logic [TAG_W-1:0] tag, input logic [23:0] c0, input logic [23:0] c1,
                              input logic [23:0] c2, input logic alpha, input bit hold);
        bit ok = 1'b0;
        @(posedge sclk);
        #1;
        blk_tag = tag; blk_c0 = c0; blk_c1 = c1; blk_c2 = c2; blk_alpha = alpha;
        blk_valid = 1'b1;
        for (int i = 0; i < 300; i++) begin
            wait_neg();
            if (blk_ready) begin ok = 1'b1; break; end
        end
        chk("blk_accept", ok, 1);
        @(posedge sclk);
        #1;
        if (!hold) blk_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            wait_neg();
            if (!busy && !pix_valid && exp_q.size() == 0) begin ok = 1'b1; break; end
        end
        chk(tag, ok, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rsrt = 1'b0; blk_valid = 1'b0; blk_alpha = 1'b0; blk_tag = '0;
        blk_c0 = '0; blk_c1 = '0; blk_c2 = '0; pix_ready = 1'b1;
        repeat (3) @(posedge sclk);
        #1;
        chk("rst_blk_ready", blk_ready, 1);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_gen_rtr", gen_rtr, 0);
        chk("rst_pix_word", {pix_tag, pix_last, pix_xy, pix_rgba}, 0);
        chk("rst_gen_c0", gen_c0, 0);
        rsrt = 1'b1;

        // Basic stream: gap-free 16 pixels, fixed pipeline latency
        rdy_mode = 0;
        send_block(8'hA5, 24'h102030, 24'h506070, 24'h203040, 1'b1, 1'b0);
        wait_idle("basic_drain");
        chk("basic_first_latency", first_cyc - hs_cyc, 3);
        chk("basic_span", last_cyc - first_cyc, 15);
        chk("basic_blk_ready", blk_ready, 1);

        // Backpressure with ready pattern 1,0,0,1
        rdy_mode = 1;
        for (int b = 0; b < 3; b++) begin
            send_block(8'($urandom), 24'($urandom), 24'($urandom), 24'($urandom), 1'($urandom), 1'b0);
            wait_idle("bp_drain");
        end

        // Back-to-back blocks with blk_valid held high
        rdy_mode = 0;
        send_block(8'h11, 24'($urandom), 24'($urandom), 24'($urandom), 1'b1, 1'b1);
        send_block(8'h22, 24'($urandom), 24'($urandom), 24'($urandom), 1'b0, 1'b0);
        chk("b2b_ready_after_last", hs_cyc - last_cyc, 1);
        wait_idle("b2b_drain");

        // Clamp path
        send_block(8'h33, 24'h000000, 24'hFFFFFF, 24'hFFFFFF, 1'b0, 1'b0);
        wait_idle("clamp_drain");
        chk("clamp_px15", seen_rgba[15], 32'h00FFFFFF);
        chk("clamp_px0", seen_rgba[0], 32'h00000000);

        // Random descriptors under random backpressure
        rdy_mode = 2;
        for (int b = 0; b < 6; b++) begin
            send_block(8'($urandom), 24'($urandom), 24'($urandom), 24'($urandom), 1'($urandom), 1'b0);
            wait_idle("rand_drain");
        end

        // Reset mid-block after pixel 5 is accepted
        rdy_mode = 0;
        send_block(8'h5C, 24'($urandom), 24'($urandom), 24'($urandom), 1'b1, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            wait_neg();
            if (blk_pix_cnt == 6) begin ok = 1'b1; break; end
        end
        chk("rst_mid_reach_px5", ok, 1);
        @(posedge sclk);
        #1;
        rsrt = 1'b0;
        #1;
        chk("rst_mid_pix_valid", pix_valid, 0);
        chk("rst_mid_busy", busy, 0);
        repeat (2) @(posedge sclk);
        #1;
        rsrt = 1'b1;
        wait_neg();
        chk("rst_rel_busy", busy, 0);
        chk("rst_rel_blk_ready", blk_ready, 1);
        send_block(8'h6D, 24'($urandom), 24'($urandom), 24'($urandom), 1'b1, 1'b0);
        wait_idle("rst_next_drain");

        // Full buffer while draining: stall with pixel 14 at the head
        manual_rdy = 1'b1;
        rdy_mode = 3;
        send_block(8'h77, 24'($urandom), 24'($urandom), 24'($urandom), 1'b1, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            wait_neg();
            if (pix_valid && pix_xy == 4'hD) begin ok = 1'b1; break; end
        end
        chk("dfull_reach_px13", ok, 1);
        manual_rdy = 1'b0;
        wait_neg();
        for (int i = 0; i < 10; i++) begin
            chk("dfull_busy", busy, 1);
            chk("dfull_gen_rtr", gen_rtr, 0);
            wait_neg();
        end
        chk("dfull_buffered", outstanding, 2);
        chk("dfull_head", pix_xy, 4'hE);
        manual_rdy = 1'b1;
        wait_idle("dfull_drain");
        chk("dfull_blk_ready", blk_ready, 1);

        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
